// File: rtl/wash_phase_timer_pkg.sv
// Shared types and the phase-duration table for the wash phase timer.
// Durations are in seconds; the top level counts them on a prescaled tick.
package wash_timer_pkg;

  typedef enum logic [1:0] {
    PH_SOAK  = 2'b00,
    PH_WASH  = 2'b01,
    PH_RINSE = 2'b10,
    PH_SPIN  = 2'b11
  } phase_e;

  typedef enum logic [1:0] {
    M_QUICK,
    M_NORMAL,
    M_HEAVY
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } tstate_e;

  localparam int unsigned DUR_W = 5;

  // Priority decode of {mode1, mode2, mode3}; no bits set falls back to normal.
  function automatic mode_e decode_mode(input logic [2:0] mode);
    if (mode[2])      return M_QUICK;
    else if (mode[1]) return M_NORMAL;
    else if (mode[0]) return M_HEAVY;
    else              return M_NORMAL;
  endfunction

  function automatic logic [DUR_W-1:0] phase_duration(input mode_e m, input phase_e p);
    logic [DUR_W-1:0] d;
    d = 5'd0;
    case (m)
      M_QUICK: begin
        case (p)
          PH_SOAK:  d = 5'd2;
          PH_WASH:  d = 5'd4;
          PH_RINSE: d = 5'd3;
          default:  d = 5'd2;
        endcase
      end
      M_HEAVY: begin
        case (p)
          PH_SOAK:  d = 5'd10;
          PH_WASH:  d = 5'd20;
          PH_RINSE: d = 5'd12;
          default:  d = 5'd8;
        endcase
      end
      default: begin
        case (p)
          PH_SOAK:  d = 5'd5;
          PH_WASH:  d = 5'd10;
          PH_RINSE: d = 5'd6;
          default:  d = 5'd4;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wash_phase_timer_if.sv
// Timer handshake between the wash controller (master) and the phase timer (slave).
interface wash_phase_timer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             timer_enable;
  logic [1:0]       phase_sel;
  logic [2:0]       mode;
  logic             pause;
  logic             clear;
  logic             timer_done;
  logic [CNT_W-1:0] remaining;
  logic             busy;

  modport master (
    output timer_enable, phase_sel, mode, pause, clear,
    input  timer_done, remaining, busy
  );

  modport slave (
    input  timer_enable, phase_sel, mode, pause, clear,
    output timer_done, remaining, busy
  );
endinterface

// File: rtl/wash_tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV enabled cycles.
// clr has priority over en and restarts the count from zero.
module wash_tick_prescaler #(
  parameter int unsigned CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          wrap;

  assign wrap = (presc_q == PW'(CLK_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    if (clr)     presc_d = '0;
    else if (en) presc_d = wrap ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  assign tick = en && !clr && wrap;

endmodule

// File: rtl/wash_phase_timer.sv
// Phase duration timer: loads a mode/phase duration, counts it down in seconds,
// pauses on lid-open and reports a done level gated against the current phase.
module wash_phase_timer
  import wash_timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1000,
  parameter int unsigned CNT_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  wash_phase_timer_if.slave tif
);

  tstate_e          state_q;
  phase_e           phase_q;
  logic [CNT_W-1:0] remaining_q;
  logic             busy_q;

  logic abort, load, count_en, tick;

  assign abort    = tif.clear || !tif.timer_enable;
  // A phase change reloads from any state, so a new phase always restarts cleanly.
  assign load     = !abort && ((state_q == ST_IDLE) || (tif.phase_sel != phase_q));
  assign count_en = !abort && !load && (state_q == ST_RUN) && !tif.pause;

  wash_tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (count_en),
    .clr   (abort || load),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_SOAK;
      remaining_q <= '0;
      busy_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
    end else if (load) begin
      state_q     <= ST_RUN;
      phase_q     <= phase_e'(tif.phase_sel);
      remaining_q <= CNT_W'(phase_duration(decode_mode(tif.mode), phase_e'(tif.phase_sel)));
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tif.pause) begin
            state_q <= ST_PAUSE;
          end else if (tick) begin
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
            end
          end
        end
        // The resume edge only changes state; counting restarts on the edge after.
        ST_PAUSE: begin
          if (!tif.pause) state_q <= ST_RUN;
        end
        ST_DONE: begin
          remaining_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tif.remaining  = remaining_q;
  assign tif.busy       = busy_q;
  // Comparing against phase_q drops done as soon as the controller advances.
  assign tif.timer_done = (state_q == ST_DONE) && tif.timer_enable && (tif.phase_sel == phase_q);

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed timing scenarios plus a randomized run against a cycle-elapsed reference model.
module tb_wash_phase_timer;
  localparam int DIV = 4;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wash_phase_timer_if #(.CNT_W(CW)) tif ();

  wash_phase_timer #(.CLK_DIV(DIV), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tif   (tif)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: seconds table plus a count of counting cycles elapsed.
  int dur_tab [3][4] = '{'{2, 4, 3, 2}, '{5, 10, 6, 4}, '{10, 20, 12, 8}};
  bit m_active, m_paused, m_done;
  int m_phase, m_dur, m_elapsed;

  function automatic int ref_dur(input logic [2:0] md, input logic [1:0] ph);
    int row;
    row = md[2] ? 0 : md[1] ? 1 : md[0] ? 2 : 1;
    return dur_tab[row][ph];
  endfunction

  function automatic int exp_rem();
    return m_active ? (m_dur - m_elapsed / DIV) : 0;
  endfunction

  function automatic bit exp_done();
    return m_done && tif.timer_enable && (int'(tif.phase_sel) == m_phase);
  endfunction

  task automatic model_reset();
    m_active = 0; m_paused = 0; m_done = 0;
    m_phase = 0; m_dur = 0; m_elapsed = 0;
  endtask

  task automatic model_edge();
    if (tif.clear || !tif.timer_enable) begin
      m_active = 0; m_paused = 0; m_done = 0;
    end else if ((!m_active && !m_done) || int'(tif.phase_sel) != m_phase) begin
      m_phase = int'(tif.phase_sel);
      m_dur = ref_dur(tif.mode, tif.phase_sel);
      m_elapsed = 0; m_active = 1; m_paused = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 1;
    end else if (m_paused) begin
      if (!tif.pause) m_paused = 0;
    end else if (tif.pause) begin
      m_paused = 1;
    end else begin
      m_elapsed++;
      if (m_elapsed == m_dur * DIV) begin
        m_done = 1; m_active = 0;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (tif.remaining !== 8'd0) begin errors++; $display("FAIL reset_remaining: got %0d expected 0", tif.remaining); end
    checks++; if (tif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tif.busy); end
    checks++; if (tif.timer_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tif.timer_done); end
    #20 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_quick_soak();
    int n;
    tif.mode = 3'b100; tif.phase_sel = 2'b00; tif.timer_enable = 1'b1;
    adv();
    checks++; if (tif.remaining !== 8'd2) begin errors++; $display("FAIL soak_load: got %0d expected 2", tif.remaining); end
    checks++; if (tif.busy !== 1'b1) begin errors++; $display("FAIL soak_busy: got %b expected 1", tif.busy); end
    n = 0;
    while (tif.timer_done !== 1'b1 && n < 40) begin adv(); n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL soak_latency: got %0d edges expected 8", n); end
    repeat (3) adv();
    checks++; if (tif.timer_done !== 1'b1 || tif.remaining !== 8'd0) begin
      errors++; $display("FAIL soak_hold: got done=%b rem=%0d expected done=1 rem=0", tif.timer_done, tif.remaining);
    end
  endtask

  task automatic test_phase_advance();
    int n;
    tif.phase_sel = 2'b01;
    #1;
    checks++; if (tif.timer_done !== 1'b0) begin errors++; $display("FAIL advance_drop: got %b expected 0", tif.timer_done); end
    adv();
    checks++; if (tif.remaining !== 8'd4) begin errors++; $display("FAIL advance_load: got %0d expected 4", tif.remaining); end
    n = 0;
    while (tif.timer_done !== 1'b1 && n < 60) begin adv(); n++; end
    checks++; if (n != 16) begin errors++; $display("FAIL advance_latency: got %0d edges expected 16", n); end
  endtask

  task automatic test_pause();
    int n;
    logic [CW-1:0] frozen;
    bit moved;
    tif.timer_enable = 1'b0; adv();
    tif.mode = 3'b001; tif.phase_sel = 2'b01; tif.timer_enable = 1'b1;
    adv();
    checks++; if (tif.remaining !== 8'd20) begin errors++; $display("FAIL pause_load: got %0d expected 20", tif.remaining); end
    repeat (20) adv();
    frozen = tif.remaining;
    checks++; if (frozen !== 8'd15) begin errors++; $display("FAIL pause_pre: got %0d expected 15", frozen); end
    tif.pause = 1'b1;
    moved = 0;
    repeat (5) begin adv(); if (tif.remaining !== frozen) moved = 1; end
    checks++; if (moved) begin errors++; $display("FAIL pause_frozen: got rem=%0d expected %0d", tif.remaining, frozen); end
    tif.pause = 1'b0;
    n = 25;
    while (tif.timer_done !== 1'b1 && n < 200) begin adv(); n++; end
    checks++; if (n != 86) begin errors++; $display("FAIL pause_latency: got %0d edges expected 86", n); end
  endtask

  task automatic test_mode_decode();
    logic [2:0] md [2];
    int n;
    md[0] = 3'b011; md[1] = 3'b000;
    for (int i = 0; i < 2; i++) begin
      tif.timer_enable = 1'b0; adv();
      tif.mode = md[i]; tif.phase_sel = 2'b10; tif.timer_enable = 1'b1;
      adv();
      checks++; if (tif.remaining !== 8'd6) begin errors++; $display("FAIL mode_load_%b: got %0d expected 6", md[i], tif.remaining); end
      n = 0;
      while (tif.timer_done !== 1'b1 && n < 100) begin adv(); n++; end
      checks++; if (n != 24) begin errors++; $display("FAIL mode_latency_%b: got %0d expected 24", md[i], n); end
    end
  endtask

  task automatic test_cancel();
    tif.timer_enable = 1'b0; adv();
    tif.mode = 3'b100; tif.phase_sel = 2'b01; tif.timer_enable = 1'b1;
    adv();
    repeat (5) adv();
    tif.clear = 1'b1; adv(); tif.clear = 1'b0;
    checks++; if (tif.remaining !== 8'd0 || tif.busy !== 1'b0 || tif.timer_done !== 1'b0) begin
      errors++; $display("FAIL cancel_clear: got rem=%0d busy=%b done=%b expected 0/0/0", tif.remaining, tif.busy, tif.timer_done);
    end
    adv();
    checks++; if (tif.remaining !== 8'd4 || tif.busy !== 1'b1) begin
      errors++; $display("FAIL cancel_reload: got rem=%0d busy=%b expected 4/1", tif.remaining, tif.busy);
    end
  endtask

  task automatic test_reset_disable();
    int n;
    tif.timer_enable = 1'b0; adv();
    tif.mode = 3'b010; tif.phase_sel = 2'b11; tif.timer_enable = 1'b1;
    adv(); repeat (3) adv();
    checks++; if (tif.busy !== 1'b1 || tif.remaining !== 8'd4) begin
      errors++; $display("FAIL spin_run: got busy=%b rem=%0d expected 1/4", tif.busy, tif.remaining);
    end
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (tif.remaining !== 8'd0 || tif.busy !== 1'b0 || tif.timer_done !== 1'b0) begin
      errors++; $display("FAIL async_reset: got rem=%0d busy=%b done=%b expected 0/0/0", tif.remaining, tif.busy, tif.timer_done);
    end
    #2 rst_n = 1'b1;
    model_reset();
    tif.mode = 3'b100;
    adv();
    n = 0;
    while (tif.timer_done !== 1'b1 && n < 40) begin adv(); n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL spin_latency: got %0d expected 8", n); end
    tif.timer_enable = 1'b0; #1;
    checks++; if (tif.timer_done !== 1'b0) begin errors++; $display("FAIL disable_comb: got %b expected 0", tif.timer_done); end
    adv();
    tif.timer_enable = 1'b1;
    adv();
    checks++; if (tif.remaining !== 8'd2 || tif.busy !== 1'b1) begin
      errors++; $display("FAIL disable_idle_reload: got rem=%0d busy=%b expected 2/1", tif.remaining, tif.busy);
    end
  endtask

  task automatic test_random();
    rst_n = 1'b0; model_reset(); #2 rst_n = 1'b1;
    tif.timer_enable = 1'b1; tif.clear = 1'b0; tif.pause = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      tif.timer_enable = ($urandom_range(0, 99) >= 1);
      tif.clear = ($urandom_range(0, 99) < 1);
      tif.pause = ($urandom_range(0, 99) < 10);
      tif.mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 3 || (tif.timer_done && $urandom_range(0, 3) == 0))
        tif.phase_sel = 2'($urandom_range(0, 3));
      @(negedge clk);
      checks++; if (int'(tif.remaining) != exp_rem()) begin
        errors++; $display("FAIL rand_remaining c=%0d: got %0d expected %0d", c, tif.remaining, exp_rem());
      end
      checks++; if (tif.busy !== m_active) begin
        errors++; $display("FAIL rand_busy c=%0d: got %b expected %b", c, tif.busy, m_active);
      end
      checks++; if (tif.timer_done !== exp_done()) begin
        errors++; $display("FAIL rand_done c=%0d: got %b expected %b", c, tif.timer_done, exp_done());
      end
      adv();
    end
  endtask

  initial begin
    tif.timer_enable = 1'b0; tif.phase_sel = 2'b00; tif.mode = 3'b000;
    tif.pause = 1'b0; tif.clear = 1'b0;
    model_reset();
    test_reset();
    test_quick_soak();
    test_phase_advance();
    test_pause();
    test_mode_decode();
    test_cancel();
    test_reset_disable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Phase duration timer for the washing-machine controller. Consumes the controller's `timer_enable`, `phase_sel` and mode request, loads a mode-dependent duration per phase, counts it down on a prescaled second tick, and returns `timer_done`. Pauses while the lid is open and clears on cancel. Sits beside the controller FSM as the responder end of its timer handshake.

## Interface
- `CLK_DIV`, default 1000: clk cycles per one-second tick; legal range ≥ 2.
- `CNT_W`, default 8: width of `remaining`. Must hold the largest table entry, 20.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `timer_enable`  in  1: controller request; high while a timed phase is active.
- `phase_sel`  in  2: phase code. 00 = soak, 01 = wash, 10 = rinse, 11 = spin.
- `mode`  in  3: `{mode1, mode2, mode3}` from the controller.
- `pause`  in  1: lid open; freezes the countdown.
- `clear`  in  1: cancel; abort and zero the timer.
- `timer_done`  out  1: phase duration elapsed (gated level, defined below).
- `remaining`  out  CNT_W: seconds left in the current phase.
- `busy`  out  1: state is RUN or PAUSE.

## Operation
- **Mode decode (priority):** `mode[2]` gives quick, else `mode[1]` gives normal, else `mode[0]` gives heavy. Mode 000 gives normal.
- **Duration table, seconds (soak / wash / rinse / spin):**
  - quick: 2 / 4 / 3 / 2
  - normal: 5 / 10 / 6 / 4
  - heavy: 10 / 20 / 12 / 8
- **Internal registers:** `state`, `phase_q`, `remaining`, `presc` (0..CLK_DIV-1).
- **State machine:** IDLE, RUN, PAUSE, DONE.
- **Per-edge priority (highest first):**
  1. `clear`: go to IDLE, `remaining` = 0, `presc` = 0.
  2. `!timer_enable`: go to IDLE, `remaining` = 0, `presc` = 0.
  3. **Load** when `timer_enable` is high and either the state is IDLE or `phase_sel != phase_q`:
     - `remaining` = table[mode][phase_sel], `phase_q` = `phase_sel`, `presc` = 0, go to RUN.
     - Mode is sampled only at load; mode changes mid-phase are ignored.
  4. **RUN:**
     - If `pause`, go to PAUSE; `presc` and `remaining` hold.
     - Otherwise `presc` increments. When `presc == CLK_DIV-1`, `presc` wraps to 0 and `remaining` decrements.
     - When the decrement takes `remaining` 1 → 0, go to DONE on the same edge.
  5. **PAUSE:** go to RUN when `pause` is low. No counting occurs in the resume cycle's edge.
  6. **DONE:** hold `remaining` = 0 until a load or an exit via `clear` / `!timer_enable`.
- **Output gating:** `timer_done = (state == DONE) && timer_enable && (phase_sel == phase_q)`.
  - The controller advances `phase_sel` in the cycle after it sees done. The comparison drops `timer_done` in that same cycle, so a stale done can never skip a phase.
  - Done is a held level, so a controller blocked by lid or cancel does not miss it.
- **Reset values:** `state` = IDLE, `remaining` = 0, `presc` = 0, `phase_q` = 00, `busy` = 0, `timer_done` = 0.

## Timing
- Load edge E: `remaining` shows the table value from E+1.
- With no pause, `timer_done` rises at edge E + D·CLK_DIV, where D is the table value.
- Each cycle spent in PAUSE, plus the resume cycle, delays done by exactly one cycle.
- A phase change while in RUN or PAUSE reloads immediately (restart semantics).
- `clear` or `timer_enable` low takes effect at the next edge. `timer_done` is combinationally low as soon as `timer_enable` is low or `phase_sel` differs from `phase_q`.
- `pause` together with `clear`: clear wins. `pause` in the load cycle: the load happens, and PAUSE is entered on the next edge.
- Asynchronous reset mid-run returns the block to reset values immediately. There is no resume after reset.

## Structure
- **Package `wash_timer_pkg`:**
  - Phase codes `PH_SOAK` / `PH_WASH` / `PH_RINSE` / `PH_SPIN`.
  - Mode enum `M_QUICK` / `M_NORMAL` / `M_HEAVY`.
  - Timer state enum.
  - Function `phase_duration(mode, phase)` returning the table value.
- **Sub-module `wash_tick_prescaler`:**
  - Inputs: `clk`, `rst_n`, `en`, `clr`.
  - Output: a one-cycle `tick` on wrap.
  - Parameter: `CLK_DIV`.
- **Top level:** FSM, load logic and output gating.

## Test plan
All scenarios use CLK_DIV = 4.
- **Quick soak:** mode = 100, phase 00, enable at edge E → `remaining` = 2 at E+1, `timer_done` = 1 at E+8 and held while inputs are unchanged.
- **Phase advance:** with done high, switch `phase_sel` to 01 → `timer_done` drops the same cycle, `remaining` = 4 next edge, done again 16 cycles after the reload edge.
- **Pause:** mode = 001, wash (D = 20); assert `pause` for 5 cycles mid-run → done arrives exactly 6 cycles later than the 80-cycle baseline, and `remaining` is frozen during pause.
- **Mode decode:** mode 011 and mode 000 on rinse → both load 6, and done arrives at 24 cycles.
- **Cancel:** `clear` pulse mid-run → next edge `remaining` = 0, `busy` = 0, `timer_done` = 0; a following enable reloads cleanly.
- **Reset and disable:** `rst_n` low mid-spin → all outputs 0 asynchronously; `timer_enable` dropped in DONE → `timer_done` low combinationally and IDLE next edge.
